// File: rtl/mem_stage_pkg.sv
// Shared constants, payload type and alignment helper for the MEM pipeline stage.
// The helper is used only when MEM_ALIGN_CHECK_EN is defined.
package mem_pkg;

    localparam int FWD_W    = 39;
    localparam int RF_ALL_W = 6;
    localparam int MEM_OP_W = 7;

    // Bit positions inside {ld_b, ld_h, ld_w, ld_ue, st_b, st_h, st_w}
    localparam int LD_B  = 6;
    localparam int LD_H  = 5;
    localparam int LD_W  = 4;
    localparam int LD_UE = 3;
    localparam int ST_B  = 2;
    localparam int ST_H  = 1;
    localparam int ST_W  = 0;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          result;
        logic [RF_ALL_W-1:0]  rf_all;
        logic                 res_from_mem;
        logic [MEM_OP_W-1:0]  mem_op;
    } mem_payload_t;

    function automatic logic is_misaligned(input logic [MEM_OP_W-1:0] op,
                                           input logic [1:0]          addr);
        return ((op[LD_H] | op[ST_H]) & addr[0]) |
               ((op[LD_W] | op[ST_W]) & (addr != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EXE->MEM, MEM->WB and data SRAM signals of the MEM stage.
// mem_ale exists only when MEM_ALIGN_CHECK_EN is defined.
interface mem_stage_if;
    import mem_pkg::*;

    logic                 exe_to_mem_valid;
    logic                 mem_allowin;
    logic [31:0]          exe_pc;
    logic [31:0]          exe_result;
    logic [RF_ALL_W-1:0]  exe_rf_all;
    logic                 exe_res_from_mem;
    logic [MEM_OP_W-1:0]  exe_mem_op;
    logic [31:0]          exe_rkd_value;

    logic                 wb_allowin;
    logic                 mem_to_wb_valid;
    logic [31:0]          mem_pc;
    logic [RF_ALL_W-1:0]  mem_rf_all;
    logic [31:0]          mem_final_result;
    logic [FWD_W-1:0]     mem_fwd_all;

    logic                 data_sram_en;
    logic [3:0]           data_sram_we;
    logic [31:0]          data_sram_addr;
    logic [31:0]          data_sram_wdata;
    logic [31:0]          data_sram_rdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic                 mem_ale;
`endif

    modport slave (
`ifdef MEM_ALIGN_CHECK_EN
        output mem_ale,
`endif
        input  exe_to_mem_valid, exe_pc, exe_result, exe_rf_all,
               exe_res_from_mem, exe_mem_op, exe_rkd_value,
               wb_allowin, data_sram_rdata,
        output mem_allowin, mem_to_wb_valid, mem_pc, mem_rf_all,
               mem_final_result, mem_fwd_all,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

    modport master (
`ifdef MEM_ALIGN_CHECK_EN
        input  mem_ale,
`endif
        output exe_to_mem_valid, exe_pc, exe_result, exe_rf_all,
               exe_res_from_mem, exe_mem_op, exe_rkd_value,
               wb_allowin, data_sram_rdata,
        input  mem_allowin, mem_to_wb_valid, mem_pc, mem_rf_all,
               mem_final_result, mem_fwd_all,
               data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
    );

endinterface

// File: rtl/mem_stage_load_extend.sv
// Selects the loaded byte/half/word from the SRAM read data and sign- or
// zero-extends it according to ld_ue.
module mem_load_extend (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic        ld_b_i,
    input  logic        ld_h_i,
    input  logic        ld_w_i,
    input  logic        ld_ue_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_i, 3'b000} +: 8];
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        result_o = rdata_i;
        if (ld_b_i) begin
            result_o = {{24{~ld_ue_i & byte_sel[7]}}, byte_sel};
        end else if (ld_h_i) begin
            result_o = {{16{~ld_ue_i & half_sel[15]}}, half_sel};
        end else if (ld_w_i) begin
            result_o = rdata_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues the data SRAM request on the EXE->MEM transfer and
// formats load data once it returns. MEM_ALIGN_CHECK_EN adds misalignment flagging.
module mem_stage
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    mem_stage_if.slave pipe_if
);

    mem_payload_t payload_q, payload_d;
    logic         mem_valid_q, mem_valid_d;
    logic         allowin;
    logic         accept;
    logic         is_mem_op;
    logic [1:0]   exe_addr_lo;
    logic [3:0]   store_we;
    logic [31:0]  store_wdata;
    logic [31:0]  load_result;
    logic [31:0]  final_result;

    assign allowin     = ~mem_valid_q | pipe_if.wb_allowin;
    assign accept      = pipe_if.exe_to_mem_valid & allowin;
    assign exe_addr_lo = pipe_if.exe_result[1:0];
    assign is_mem_op   = |{pipe_if.exe_mem_op[LD_B], pipe_if.exe_mem_op[LD_H],
                           pipe_if.exe_mem_op[LD_W], pipe_if.exe_mem_op[ST_B],
                           pipe_if.exe_mem_op[ST_H], pipe_if.exe_mem_op[ST_W]};

    always_comb begin
        mem_valid_d = mem_valid_q;
        payload_d   = payload_q;
        if (allowin) begin
            mem_valid_d = pipe_if.exe_to_mem_valid;
        end
        if (accept) begin
            payload_d.pc           = pipe_if.exe_pc;
            payload_d.result       = pipe_if.exe_result;
            payload_d.rf_all       = pipe_if.exe_rf_all;
            payload_d.res_from_mem = pipe_if.exe_res_from_mem;
            payload_d.mem_op       = pipe_if.exe_mem_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
            payload_q   <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            payload_q   <= payload_d;
        end
    end

    // Byte lanes and replicated write data for the store in EXE
    always_comb begin
        store_we    = 4'b0000;
        store_wdata = pipe_if.exe_rkd_value;
        if (pipe_if.exe_mem_op[ST_B]) begin
            store_we    = 4'b0001 << exe_addr_lo;
            store_wdata = {4{pipe_if.exe_rkd_value[7:0]}};
        end else if (pipe_if.exe_mem_op[ST_H]) begin
            store_we    = exe_addr_lo[1] ? 4'b1100 : 4'b0011;
            store_wdata = {2{pipe_if.exe_rkd_value[15:0]}};
        end else if (pipe_if.exe_mem_op[ST_W]) begin
            store_we    = 4'b1111;
        end
`ifdef MEM_ALIGN_CHECK_EN
        if (is_misaligned(pipe_if.exe_mem_op, exe_addr_lo)) begin
            store_we = 4'b0000;
        end
`endif
    end

    assign pipe_if.data_sram_en    = accept & is_mem_op;
    assign pipe_if.data_sram_we    = pipe_if.data_sram_en ? store_we : 4'b0000;
    assign pipe_if.data_sram_addr  = {pipe_if.exe_result[31:2], 2'b00};
    assign pipe_if.data_sram_wdata = store_wdata;

    // Read data is held stable during a stall, so the result is simply recomputed
    mem_load_extend u_load_extend (
        .rdata_i  (pipe_if.data_sram_rdata),
        .addr_i   (payload_q.result[1:0]),
        .ld_b_i   (payload_q.mem_op[LD_B]),
        .ld_h_i   (payload_q.mem_op[LD_H]),
        .ld_w_i   (payload_q.mem_op[LD_W]),
        .ld_ue_i  (payload_q.mem_op[LD_UE]),
        .result_o (load_result)
    );

    assign final_result = payload_q.res_from_mem ? load_result : payload_q.result;

    assign pipe_if.mem_allowin      = allowin;
    assign pipe_if.mem_to_wb_valid  = mem_valid_q;
    assign pipe_if.mem_pc           = payload_q.pc;
    assign pipe_if.mem_rf_all       = payload_q.rf_all;
    assign pipe_if.mem_final_result = final_result;
    assign pipe_if.mem_fwd_all      = {payload_q.res_from_mem,
                                       payload_q.rf_all[RF_ALL_W-1] & mem_valid_q,
                                       payload_q.rf_all[RF_ALL_W-2:0],
                                       final_result};

`ifdef MEM_ALIGN_CHECK_EN
    assign pipe_if.mem_ale = mem_valid_q & is_misaligned(payload_q.mem_op, payload_q.result[1:0]);
`endif

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-002 resetn  in  1  reset, synchronous, active-low; clock clk.
REQ-003 exe_to_mem_valid  in  1  EXE holds a completed instruction.
REQ-004 mem_allowin  out  1  MEM accepts a new instruction this cycle.
REQ-005 exe_pc  in  32  PC of the EXE instruction.
REQ-006 exe_result  in  32  ALU/mul/div result; the effective address for loads and stores.
REQ-007 exe_rf_all  in  6  {rf_we, rf_waddr[4:0]}.
REQ-008 exe_res_from_mem  in  1  instruction is a load.
REQ-009 exe_mem_op  in  7  {ld_b, ld_h, ld_w, ld_ue, st_b, st_h, st_w}, one-hot except ld_ue.
REQ-010 exe_rkd_value  in  32  store data.
REQ-011 wb_allowin  in  1  WB accepts.
REQ-012 mem_to_wb_valid  out  1  MEM passes an instruction to WB.
REQ-013 mem_pc  out  32  latched PC.
REQ-014 mem_rf_all  out  6  latched {rf_we, rf_waddr}.
REQ-015 mem_final_result  out  32  extended load data or the latched exe_result.
REQ-016 mem_fwd_all  out  39  {res_from_mem, rf_we & mem_valid, rf_waddr, mem_final_result}, for ID bypass.
REQ-017 data_sram_en, data_sram_we[3:0], data_sram_addr[31:0], data_sram_wdata[31:0]  out  synchronous data SRAM request.
REQ-018 data_sram_rdata  in  32  read data, valid one cycle after the request.
REQ-019 mem_ale  out  1  misaligned-access flag; present only under MEM_ALIGN_CHECK_EN.

Function
REQ-020 mem_ready_go is a constant 1; mem_allowin = ~mem_valid | wb_allowin; mem_to_wb_valid = mem_valid.
REQ-021 On each clock, when mem_allowin=1, mem_valid <= exe_to_mem_valid; otherwise mem_valid holds.
REQ-022 Payload registers (pc, result, rf_all, res_from_mem, mem_op, addr[1:0]) load only when exe_to_mem_valid & mem_allowin.
REQ-023 data_sram_en = exe_to_mem_valid & mem_allowin & (any ld or st bit); the request is issued in the EXE->MEM transfer cycle.
REQ-024 data_sram_addr = {exe_result[31:2], 2'b00}.
REQ-025 Byte enables:
- st_b: 4'b0001 << addr[1:0].
- st_h: addr[1] ? 4'b1100 : 4'b0011.
- st_w: 4'b1111.
- Loads and non-memory instructions: 4'b0000.
REQ-026 wdata: st_b replicates rkd[7:0] x4; st_h replicates rkd[15:0] x2; st_w passes rkd unchanged.
REQ-027 Load result is selected from data_sram_rdata using the latched addr[1:0]:
- ld_b: byte addr[1:0].
- ld_h: half addr[1].
- Extension: sign-extended if ld_ue=0, zero-extended if ld_ue=1.
- ld_w: the full word.
REQ-028 mem_final_result = res_from_mem ? load result : latched exe_result.
REQ-029 While MEM stalls (wb_allowin=0), no new request is issued, so data_sram_rdata stays stable; the result is recomputed each cycle, and no capture register is required.
REQ-030 A simultaneous WB accept and EXE offer in the same cycle replaces the MEM contents seamlessly: zero bubble, throughput 1 instruction per cycle.
REQ-031 mem_fwd_all rf_we bit is 0 whenever mem_valid=0.

Reset
REQ-032 When resetn=0 at a clock edge:
- mem_valid <= 0 and mem_rf_all <= 0.
- Hence mem_to_wb_valid=0 and the mem_fwd_all rf_we bit is 0.
- data_sram_en=0 provided exe_to_mem_valid=0.
REQ-033 Reset during a stall discards the held instruction; no retry is issued afterwards.

Configuration
REQ-034 With MEM_ALIGN_CHECK_EN defined:
- mem_ale=1 when ld_h/st_h has addr[0]=1, or ld_w/st_w has addr[1:0]!=0.
- A misaligned store forces data_sram_we=0.
- A misaligned load still writes back.
REQ-035 Without MEM_ALIGN_CHECK_EN:
- No mem_ale port exists.
- Low address bits beyond the access size are ignored: st_h uses addr[1] only; st_w/ld_w ignore addr[1:0].

Structure
REQ-036 Package mem_pkg holds:
- MEM_OP index constants (LD_B..ST_W).
- Width constants: FWD_W=39, RF_ALL_W=6, MEM_OP_W=7.
REQ-037 Sub-module mem_load_extend: combinational; inputs rdata, addr[1:0], ld_b/ld_h/ld_w/ld_ue; output result.

Verification
REQ-038 st_b, addr=0x1003, rkd=0x000000A5 -> we=4'b1000, wdata=0xA5A5A5A5, sram_addr=0x1000.
REQ-039 ld_b, addr=0x1002, rdata=0x11807F22 next cycle -> mem_final_result=0xFFFFFF80; repeated with ld_ue=1 -> 0x00000080.
REQ-040 ld_h, addr=0x2002, rdata=0x8001ABCD -> 0xFFFF8001; ld_w -> 0x8001ABCD.
REQ-041 wb_allowin=0 for 3 cycles with a load in MEM:
- data_sram_en=0 and mem_allowin=0 throughout.
- Result stable throughout.
- Exactly one transfer to WB after release.
REQ-042 Non-memory add, exe_result=0x12345678, rf_all={1,5'd7} -> en=0, mem_final_result=0x12345678, mem_fwd_all={1'b0,1'b1,5'd7,0x12345678}.
REQ-043 MEM_ALIGN_CHECK_EN, st_w addr=0x3002 -> mem_ale=1, we=4'b0000; resetn=0 mid-stall -> mem_to_wb_valid=0 next cycle.
